// File: rtl/pos_frame_rx_if.sv
// Software-to-hardware position handshake bus: coordinate word, object index,
// 2-bit command from software and 2-bit status back from hardware.
interface pos_frame_rx_if #(
  parameter int unsigned COORD_W = 10,
  parameter int unsigned IDX_W   = 5
) ();
  logic [COORD_W-1:0] x_to_hw;
  logic [COORD_W-1:0] y_to_hw;
  logic [IDX_W-1:0]   idx_to_hw;
  logic [1:0]         to_hw_sig;
  logic [1:0]         to_sw_sig;

  // Software side drives the word and command, reads status.
  modport master (
    output x_to_hw, y_to_hw, idx_to_hw, to_hw_sig,
    input  to_sw_sig
  );

  // Hardware side samples the word and command, drives status.
  modport slave (
    input  x_to_hw, y_to_hw, idx_to_hw, to_hw_sig,
    output to_sw_sig
  );
endinterface

// File: rtl/pos_frame_rx.sv
// Receives per-object x/y positions from software over a 4-phase handshake,
// stages them in a shadow buffer and commits a whole frame atomically on
// end-of-frame.
module pos_frame_rx #(
  parameter int unsigned NUM_OBJ     = 17,
  parameter int unsigned COORD_W     = 10,
  parameter int unsigned IDX_W       = 5,
  parameter int unsigned TIMEOUT_CYC = 1023
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       run,
  pos_frame_rx_if.slave              sw,
  output logic [NUM_OBJ*COORD_W-1:0] pos_x,
  output logic [NUM_OBJ*COORD_W-1:0] pos_y,
  output logic                       frame_done,
  output logic [7:0]                 frame_cnt,
  output logic                       err_bad_idx,
  output logic                       err_timeout
);

  // Counter only needs to reach TIMEOUT_CYC; keep at least one bit when disabled.
  localparam int unsigned TO_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [TO_W-1:0]  TO_MAX  = TO_W'(TIMEOUT_CYC);
  localparam logic [IDX_W:0]   OBJ_LIM = (IDX_W + 1)'(NUM_OBJ);

  localparam logic [1:0] CMD_WR  = 2'd1;
  localparam logic [1:0] CMD_EOF = 2'd3;
  localparam logic [1:0] CMD_IDL = 2'd0;

  localparam logic [1:0] STS_IDLE = 2'd0;
  localparam logic [1:0] STS_ACK  = 2'd1;
  localparam logic [1:0] STS_ERR  = 2'd2;

  // Index width must be able to address every object.
  if ((2 ** IDX_W) < NUM_OBJ) begin : g_idx_w_check
    $error("pos_frame_rx: IDX_W too small for NUM_OBJ");
  end

  typedef enum logic [2:0] {
    S_HALT,
    S_IDLE,
    S_CAPTURE,
    S_ACK,
    S_COMMIT,
    S_ERROR
  } state_t;

  state_t             state;
  logic [TO_W-1:0]    ack_cnt;
  logic [NUM_OBJ-1:0] pending;
  logic [COORD_W-1:0] shadow_x [NUM_OBJ];
  logic [COORD_W-1:0] shadow_y [NUM_OBJ];
  logic               idx_ok;

  // Index range check, widened so NUM_OBJ == 2**IDX_W still compares correctly.
  assign idx_ok = ({1'b0, sw.idx_to_hw} < OBJ_LIM);

  // Handshake FSM, shadow buffer, commit datapath and status flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= S_HALT;
      sw.to_sw_sig  <= STS_IDLE;
      ack_cnt       <= '0;
      pending       <= '0;
      pos_x         <= '0;
      pos_y         <= '0;
      frame_done    <= 1'b0;
      frame_cnt     <= '0;
      err_bad_idx   <= 1'b0;
      err_timeout   <= 1'b0;
      for (int k = 0; k < NUM_OBJ; k++) begin
        shadow_x[k] <= '0;
        shadow_y[k] <= '0;
      end
    end else begin
      frame_done <= 1'b0;
      case (state)
        S_HALT: begin
          if (run) begin
            state <= S_IDLE;
          end
        end

        S_IDLE: begin
          if (!run) begin
            state <= S_HALT;
          end else if (sw.to_hw_sig == CMD_WR) begin
            state <= S_CAPTURE;
          end else if (sw.to_hw_sig == CMD_EOF) begin
            state <= S_COMMIT;
          end
        end

        S_CAPTURE: begin
          if (idx_ok) begin
            for (int k = 0; k < NUM_OBJ; k++) begin
              if (sw.idx_to_hw == IDX_W'(k)) begin
                shadow_x[k] <= sw.x_to_hw;
                shadow_y[k] <= sw.y_to_hw;
                pending[k]  <= 1'b1;
              end
            end
            state        <= S_ACK;
            ack_cnt      <= '0;
            sw.to_sw_sig <= STS_ACK;
          end else begin
            err_bad_idx  <= 1'b1;
            state        <= S_ERROR;
            sw.to_sw_sig <= STS_ERR;
          end
        end

        S_ACK: begin
          if ((sw.to_hw_sig != CMD_WR) && (sw.to_hw_sig != CMD_EOF)) begin
            state        <= S_IDLE;
            sw.to_sw_sig <= STS_IDLE;
          end else if ((TIMEOUT_CYC != 0) && (ack_cnt == TO_MAX)) begin
            err_timeout  <= 1'b1;
            state        <= S_ERROR;
            sw.to_sw_sig <= STS_ERR;
          end else begin
            ack_cnt <= ack_cnt + 1'b1;
          end
        end

        S_COMMIT: begin
          for (int k = 0; k < NUM_OBJ; k++) begin
            if (pending[k]) begin
              pos_x[k*COORD_W +: COORD_W] <= shadow_x[k];
              pos_y[k*COORD_W +: COORD_W] <= shadow_y[k];
            end
          end
          pending      <= '0;
          frame_done   <= 1'b1;
          frame_cnt    <= frame_cnt + 8'd1;
          state        <= S_ACK;
          ack_cnt      <= '0;
          sw.to_sw_sig <= STS_ACK;
        end

        S_ERROR: begin
          pending <= '0;
          if (sw.to_hw_sig == CMD_IDL) begin
            state        <= S_IDLE;
            sw.to_sw_sig <= STS_IDLE;
          end
        end

        default: begin
          state        <= S_HALT;
          sw.to_sw_sig <= STS_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pos_frame_rx.sv
// Bench for pos_frame_rx: table of write/end-of-frame vectors driven through
// the handshake, a reference model of shadow/pending/committed state, and a
// scoreboard of expected commits checked on every frame_done pulse.
module tb_pos_frame_rx;
  localparam int unsigned NUM_OBJ     = 17;
  localparam int unsigned COORD_W     = 10;
  localparam int unsigned IDX_W       = 5;
  localparam int unsigned TIMEOUT_CYC = 8;
  localparam int unsigned PW          = NUM_OBJ * COORD_W;

  logic          clk = 1'b0;
  logic          reset;
  logic          run;
  logic [PW-1:0] pos_x;
  logic [PW-1:0] pos_y;
  logic          frame_done;
  logic [7:0]    frame_cnt;
  logic          err_bad_idx;
  logic          err_timeout;

  pos_frame_rx_if #(.COORD_W(COORD_W), .IDX_W(IDX_W)) sw ();

  pos_frame_rx #(
    .NUM_OBJ(NUM_OBJ), .COORD_W(COORD_W), .IDX_W(IDX_W), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk(clk), .reset(reset), .run(run), .sw(sw),
    .pos_x(pos_x), .pos_y(pos_y), .frame_done(frame_done), .frame_cnt(frame_cnt),
    .err_bad_idx(err_bad_idx), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int pulses   = 0;

  // Reference model.
  logic [COORD_W-1:0] m_sx [NUM_OBJ];
  logic [COORD_W-1:0] m_sy [NUM_OBJ];
  logic [NUM_OBJ-1:0] m_pend;
  logic [PW-1:0]      m_px;
  logic [PW-1:0]      m_py;
  logic [7:0]         m_cnt;

  typedef struct {
    logic [7:0]    cnt;
    logic [PW-1:0] px;
    logic [PW-1:0] py;
  } exp_t;
  exp_t sbq[$];
  exp_t e_mon;

  typedef struct {
    bit                 eof;
    logic [IDX_W-1:0]   idx;
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic [1:0]         exp_sig;
  } vec_t;
  vec_t tbl[12];

  task automatic check(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_clear();
    for (int k = 0; k < NUM_OBJ; k++) begin
      m_sx[k] = '0;
      m_sy[k] = '0;
    end
    m_pend = '0;
    m_px   = '0;
    m_py   = '0;
    m_cnt  = '0;
    sbq.delete();
  endtask

  // Scoreboard: every frame_done pops one expected commit.
  always @(negedge clk) begin
    if (!reset && frame_done) begin
      pulses++;
      if (sbq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_frame_done: got pulse expected none (frame_cnt=%0d)", frame_cnt);
      end else begin
        e_mon = sbq.pop_front();
        check("commit_frame_cnt", PW'(frame_cnt), PW'(e_mon.cnt));
        check("commit_pos_x", pos_x, e_mon.px);
        check("commit_pos_y", pos_y, e_mon.py);
      end
    end
  end

  task automatic wait_sig(input logic [1:0] want, input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (sw.to_sw_sig == want) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL %s: to_sw_sig got %0d expected %0d (timed out)", name, sw.to_sw_sig, want);
    end
  endtask

  task automatic do_write(input logic [IDX_W-1:0] idx, input logic [COORD_W-1:0] x,
                          input logic [COORD_W-1:0] y, input logic [1:0] exp_sig);
    bit got = 1'b0;
    sw.x_to_hw   = x;
    sw.y_to_hw   = y;
    sw.idx_to_hw = idx;
    sw.to_hw_sig = 2'd1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (sw.to_sw_sig != 2'd0) begin
        got = 1'b1;
        break;
      end
    end
    check("write_status", PW'(sw.to_sw_sig), PW'(exp_sig));
    if (!got) $display("FAIL write_wait: no status for idx %0d", idx);
    if (32'(idx) < NUM_OBJ) begin
      m_sx[idx]   = x;
      m_sy[idx]   = y;
      m_pend[idx] = 1'b1;
    end else begin
      m_pend = '0;
    end
    if (sw.to_sw_sig == 2'd2) begin
      sw.to_hw_sig = 2'd0;
      wait_sig(2'd0, "err_exit");
    end else begin
      sw.to_hw_sig = 2'd2;
      wait_sig(2'd0, "ack_drop");
      sw.to_hw_sig = 2'd0;
    end
    check("pos_x_unchanged_after_write", pos_x, m_px);
    check("pos_y_unchanged_after_write", pos_y, m_py);
  endtask

  task automatic do_eof();
    exp_t e;
    int   p0 = pulses;
    for (int k = 0; k < NUM_OBJ; k++) begin
      if (m_pend[k]) begin
        m_px[k*COORD_W +: COORD_W] = m_sx[k];
        m_py[k*COORD_W +: COORD_W] = m_sy[k];
      end
    end
    m_pend = '0;
    m_cnt  = m_cnt + 8'd1;
    e.cnt  = m_cnt;
    e.px   = m_px;
    e.py   = m_py;
    sbq.push_back(e);
    sw.to_hw_sig = 2'd3;
    wait_sig(2'd1, "eof_ack");
    sw.to_hw_sig = 2'd2;
    wait_sig(2'd0, "eof_ack_drop");
    sw.to_hw_sig = 2'd0;
    @(negedge clk);
    check("frame_done_pulses_per_eof", PW'(pulses - p0), PW'(1));
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_pos_x"}, pos_x, '0);
    check({tag, "_pos_y"}, pos_y, '0);
    check({tag, "_frame_cnt"}, PW'(frame_cnt), '0);
    check({tag, "_frame_done"}, PW'(frame_done), '0);
    check({tag, "_err_bad_idx"}, PW'(err_bad_idx), '0);
    check({tag, "_err_timeout"}, PW'(err_timeout), '0);
    check({tag, "_to_sw_sig"}, PW'(sw.to_sw_sig), '0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    tbl[0]  = '{1'b0, 5'd0,  10'd100,  10'd200, 2'd1};
    tbl[1]  = '{1'b0, 5'd16, 10'd1023, 10'd0,   2'd1};
    tbl[2]  = '{1'b1, 5'd0,  10'd0,    10'd0,   2'd1};
    tbl[3]  = '{1'b0, 5'd3,  10'd5,    10'd6,   2'd1};
    tbl[4]  = '{1'b0, 5'd5,  10'd1,    10'd2,   2'd1};
    tbl[5]  = '{1'b0, 5'd5,  10'd300,  10'd400, 2'd1};
    tbl[6]  = '{1'b1, 5'd0,  10'd0,    10'd0,   2'd1};
    tbl[7]  = '{1'b0, 5'd7,  10'd2,    10'd3,   2'd1};
    tbl[8]  = '{1'b0, 5'd20, 10'd9,    10'd9,   2'd2};
    tbl[9]  = '{1'b1, 5'd0,  10'd0,    10'd0,   2'd1};
    tbl[10] = '{1'b0, 5'd31, 10'd1,    10'd1,   2'd2};
    tbl[11] = '{1'b1, 5'd0,  10'd0,    10'd0,   2'd1};

    model_clear();
    reset        = 1'b1;
    run          = 1'b0;
    sw.x_to_hw   = '0;
    sw.y_to_hw   = '0;
    sw.idx_to_hw = '0;
    sw.to_hw_sig = 2'd0;
    repeat (3) @(negedge clk);
    check_reset_state("reset");
    reset = 1'b0;

    // Stays in HALT while run is low, even with a write request present.
    sw.to_hw_sig = 2'd1;
    repeat (5) @(negedge clk);
    check("halt_ignores_request", PW'(sw.to_sw_sig), '0);
    sw.to_hw_sig = 2'd0;
    run = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 12; i++) begin
      if (tbl[i].eof) do_eof();
      else do_write(tbl[i].idx, tbl[i].x, tbl[i].y, tbl[i].exp_sig);
      if (i == 2) begin
        check("obj0_x", PW'(pos_x[0 +: COORD_W]), PW'(100));
        check("obj0_y", PW'(pos_y[0 +: COORD_W]), PW'(200));
        check("obj16_x", PW'(pos_x[16*COORD_W +: COORD_W]), PW'(1023));
        check("obj16_y", PW'(pos_y[16*COORD_W +: COORD_W]), PW'(0));
        check("frame_cnt_1", PW'(frame_cnt), PW'(1));
      end
    end
    check("obj3_x", PW'(pos_x[3*COORD_W +: COORD_W]), PW'(5));
    check("obj5_y_last_wins", PW'(pos_y[5*COORD_W +: COORD_W]), PW'(400));
    check("obj7_discarded", PW'(pos_x[7*COORD_W +: COORD_W]), PW'(0));
    check("err_bad_idx_sticky", PW'(err_bad_idx), PW'(1));
    check("err_timeout_clear", PW'(err_timeout), PW'(0));

    // ACK held past the timeout.
    sw.idx_to_hw = 5'd1;
    sw.x_to_hw   = 10'd11;
    sw.y_to_hw   = 10'd12;
    sw.to_hw_sig = 2'd1;
    wait_sig(2'd1, "timeout_first_ack");
    n = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      n++;
      if (n == 4) check("still_ack_before_timeout", PW'(sw.to_sw_sig), PW'(1));
      if (sw.to_sw_sig == 2'd2) break;
    end
    check("timeout_status", PW'(sw.to_sw_sig), PW'(2));
    check("timeout_flag", PW'(err_timeout), PW'(1));
    checks++;
    if (n < 8 || n > 9) begin
      failures++;
      $display("FAIL timeout_latency: got %0d cycles expected 8..9", n);
    end
    m_pend = '0;
    sw.to_hw_sig = 2'd0;
    wait_sig(2'd0, "timeout_exit");
    do_eof();
    check("obj1_not_committed", PW'(pos_x[1*COORD_W +: COORD_W]), PW'(0));

    // Reset mid-handshake after two writes.
    do_write(5'd4, 10'd9, 10'd9, 2'd1);
    do_write(5'd6, 10'd8, 10'd8, 2'd1);
    sw.idx_to_hw = 5'd8;
    sw.to_hw_sig = 2'd1;
    wait_sig(2'd1, "pre_reset_ack");
    reset = 1'b1;
    #1;
    check_reset_state("async_reset");
    @(negedge clk);
    reset = 1'b0;
    sw.to_hw_sig = 2'd0;
    model_clear();
    run = 1'b0;
    sw.to_hw_sig = 2'd1;
    repeat (4) @(negedge clk);
    check("halt_after_reset", PW'(sw.to_sw_sig), '0);
    sw.to_hw_sig = 2'd0;
    run = 1'b1;
    repeat (2) @(negedge clk);
    do_write(5'd2, 10'd4, 10'd4, 2'd1);
    do_eof();

    // frame_cnt wrap over 256 empty frames.
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_clear();
    repeat (2) @(negedge clk);
    n = pulses;
    for (int i = 0; i < 256; i++) do_eof();
    check("wrap_pulses", PW'(pulses - n), PW'(256));
    check("wrap_frame_cnt", PW'(frame_cnt), PW'(0));
    check("scoreboard_drained", PW'(sbq.size()), '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
